mem_port_arbiter: RTL

//  Shares one single-ported, variable-latency memory between instruction fetch (F stage)
//  and data access (M stage) of the pipelined MIPS core.

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-ported variable-latency memory
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [3:0] STARVE_LIM  = 4'(STARVE_MAX);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  state_t      state, state_nx;
  logic [3:0]  starve_cnt;
  logic [7:0]  wait_cnt;
  logic        in_gnt, expired, finish, time_out;
  logic        grant_i, grant_d;

  // A transfer ends on mem_ready; if the memory never answers, the wait budget forces it.
  assign in_gnt   = (state != IDLE);
  assign expired  = (wait_cnt == TIMEOUT_LIM);
  assign finish   = in_gnt && (mem_ready || expired);
  assign time_out = in_gnt && !mem_ready && expired;

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    case (state)
      IDLE: begin
        // Data wins contention until fetch has been passed over STARVE_MAX times.
        if (dm_req && (!if_req || starve_cnt != STARVE_LIM)) begin
          grant_d  = 1'b1;
          state_nx = GNT_D;
        end else if (if_req) begin
          grant_i  = 1'b1;
          state_nx = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (finish) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_i || grant_d) begin
        mem_valid <= 1'b1;
        mem_we    <= grant_d && dm_we;
        mem_addr  <= grant_d ? dm_addr : if_addr;
        mem_wdata <= grant_d ? dm_wdata : '0;
        wait_cnt  <= '0;
      end else if (finish) begin
        mem_valid <= 1'b0;
        mem_we    <= 1'b0;
      end else if (in_gnt) begin
        wait_cnt  <= wait_cnt + 8'd1;
      end

      if (grant_i)
        starve_cnt <= '0;
      else if (grant_d && if_req && starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;

      if (time_out)
        err <= 1'b1;
    end
  end

  assign if_done  = (state == GNT_I) && finish;
  assign dm_done  = (state == GNT_D) && finish;
  assign if_rdata = (state == GNT_I && mem_ready) ? mem_rdata : '0;
  assign dm_rdata = (state == GNT_D && mem_ready) ? mem_rdata : '0;

  assign stall_if = if_req && !if_done;
  assign stall_dm = dm_req && !dm_done;

endmodule
